// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t    : fetch FSM state encoding (also exported as a debug port)
//   NOP_INSTR        : instruction word presented after reset (addi x0,x0,0)
//   DEFAULT_RESET_PC : default word index loaded into the PC on reset
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// next_pc_logic: combinational next-PC selection for the fetch stage.
//   pc            in  : address of the instruction being accepted
//   br_taken      in  : redirect to br_target instead of falling through
//   br_target     in  : redirect word index from the ALU
//   next_pc       out : selected next fetch address (wraps modulo 2^XLEN)
//   next_pc_plus1 out : next_pc + 1, so the link value can be registered
//                       alongside the new pc without a second adder stage
module next_pc_logic #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] next_pc_plus1
);

  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] pc_plus1;

  assign pc_plus1      = pc + ONE;
  assign next_pc       = br_taken ? br_target : pc_plus1;
  assign next_pc_plus1 = next_pc + ONE;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage; owns the program counter.
//   clk, reset             : clock, asynchronous active-high reset
//   imem_req / imem_addr   : one-cycle word-addressed request to instruction memory
//   imem_rvalid/imem_rdata : memory response, only honoured in WAIT
//   instr_valid, instruction, pc, pc_plus1 : presented instruction for the datapath
//   stall                  : datapath cannot consume this cycle
//   br_taken / br_target   : redirect, only used on an accept cycle
//   retired                : count of accepted instructions
//   state                  : current FSM state (debug visibility)
//
// Handshake: an instruction is accepted on a rising edge where instr_valid=1
// and stall=0. While stall=1 every output holds and br_taken is ignored.
// Every output is a register, so imem_req/imem_addr/instr_valid have no
// combinational path from any input.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instruction,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus1,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  output logic [CNT_W-1:0] retired,
  output fetch_state_t     state
);

  localparam logic [XLEN-1:0]  RESET_PC_PLUS1 = RESET_PC + {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] next_pc_plus1;
  logic            accept;

  next_pc_logic #(
    .XLEN (XLEN)
  ) u_next_pc (
    .pc            (pc),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .next_pc       (next_pc),
    .next_pc_plus1 (next_pc_plus1)
  );

  assign accept = (state == VALID) && instr_valid && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pc_plus1    <= RESET_PC_PLUS1;
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      retired     <= '0;
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        REQ: begin
          // Single-cycle pulse; imem_addr keeps its value but is only
          // meaningful while imem_req is high.
          state    <= WAIT;
          imem_req <= 1'b0;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instruction <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (accept) begin
            retired     <= retired + CNT_ONE;
            pc          <= next_pc;
            pc_plus1    <= next_pc_plus1;
            instr_valid <= 1'b0;
            // The next request is launched straight from the accept edge so
            // REQ already drives the new address.
            imem_req    <= 1'b1;
            imem_addr   <= next_pc;
            state       <= REQ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit with a
// transaction-level PC/retire model and a latency-programmable memory.
module tb_fetch_unit;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        imem_req, instr_valid, stall, br_taken;
  logic [31:0] imem_addr, instruction, pc, pc_plus1, br_target, retired;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  fetch_state_t state;

  // second instance exercising PC wrap from the top of the address space
  logic        reset2 = 1'b1;
  logic        imem_req2, instr_valid2, imem_rvalid2, stall2, br_taken2;
  logic [31:0] imem_addr2, instruction2, pc2, pc_plus1_2, imem_rdata2, br_target2, retired2;
  fetch_state_t state2;

  fetch_unit u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instruction(instruction), .pc(pc), .pc_plus1(pc_plus1), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .retired(retired), .state(state)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) u_dut_wrap (
    .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2), .instr_valid(instr_valid2),
    .instruction(instruction2), .pc(pc2), .pc_plus1(pc_plus1_2), .stall(stall2),
    .br_taken(br_taken2), .br_target(br_target2), .retired(retired2), .state(state2)
  );

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h00A0_0093;
  endfunction

  int          mem_lat  = 1;
  bit          rand_lat = 1'b0;
  bit          stray_en = 1'b0;
  bit          inj_en   = 1'b0;
  logic [31:0] inj_data = '0;
  bit          pending  = 1'b0;
  int          cnt      = 0;
  logic [31:0] paddr    = '0;

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      imem_rvalid = 1'b0;
      if (reset) pending = 1'b0;
      if (inj_en) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inj_data;
      end else if (pending) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pending     = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req && !reset) begin
        pending = 1'b1;
        paddr   = imem_addr;
        cnt     = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        if (stray_en) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'hBAD0_BAD0;
        end
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_retired = '0;
  bit          prev_valid = 1'b0;
  int          wait_cycles = 0;
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict the accept from the inputs held over the edge, then
  // compare against the DUT on the following falling edge.
  task automatic tick();
    bit          acc;
    bit          bt;
    logic [31:0] tgt;
    acc = instr_valid && !stall && !reset;
    bt  = br_taken;
    tgt = br_target;
    @(negedge clk);
    if (acc) begin
      m_retired++;
      m_pc = bt ? tgt : m_pc + 32'd1;
    end
    check("retired", {32'h0, retired}, {32'h0, m_retired});
    if (imem_req) begin
      req_log.push_back(imem_addr);
      check("imem_addr", {32'h0, imem_addr}, {32'h0, m_pc});
    end
    if (instr_valid && !prev_valid) begin
      exp_q.push_back(mem_word(m_pc));
      check("instruction", {32'h0, instruction}, {32'h0, exp_q.pop_front()});
      check("pc", {32'h0, pc}, {32'h0, m_pc});
      check("pc_plus1", {32'h0, pc_plus1}, {32'h0, m_pc + 32'd1});
    end
    if (state == WAIT) wait_cycles++;
    prev_valid = instr_valid;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 60) begin
      tick();
      n++;
    end
    if (!instr_valid) begin
      checks++;
      errors++;
      $error("FAIL wait_valid_timeout observed=%0d cycles expected=instr_valid", n);
    end
  endtask

  task automatic fetch_one(input bit br, input logic [31:0] tgt);
    wait_valid();
    stall     = 1'b0;
    br_taken  = br;
    br_target = tgt;
    tick();
    br_taken  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] snap_instr, snap_pc, snap_pc1;
    stall = 1'b0; br_taken = 1'b0; br_target = '0;
    stall2 = 1'b0; br_taken2 = 1'b0; br_target2 = '0;
    imem_rvalid2 = 1'b0; imem_rdata2 = '0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_state", {62'h0, state}, {62'h0, IDLE});
    check("rst_pc", {32'h0, pc}, 64'h0);
    check("rst_pc_plus1", {32'h0, pc_plus1}, 64'h1);
    check("rst_instruction", {32'h0, instruction}, {32'h0, NOP_INSTR});
    check("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
    check("rst_imem_req", {63'h0, imem_req}, 64'h0);
    check("rst_imem_addr", {32'h0, imem_addr}, 64'h0);
    check("rst_retired", {32'h0, retired}, 64'h0);

    // release: IDLE one cycle, REQ, WAIT (1-cycle memory), VALID
    reset = 1'b0;
    tick();
    check("first_req", {63'h0, imem_req}, 64'h1);
    check("first_state_req", {62'h0, state}, {62'h0, REQ});
    tick();
    check("req_pulse_drop", {63'h0, imem_req}, 64'h0);
    check("state_wait", {62'h0, state}, {62'h0, WAIT});
    tick();
    check("first_valid", {63'h0, instr_valid}, 64'h1);
    check("first_instr", {32'h0, instruction}, 64'h00A0_0093);

    // three sequential accepts
    repeat (3) fetch_one(1'b0, '0);
    check("retired_3", {32'h0, retired}, 64'd3);
    check("req_log_0", {32'h0, req_log[0]}, 64'd0);
    check("req_log_1", {32'h0, req_log[1]}, 64'd1);
    check("req_log_2", {32'h0, req_log[2]}, 64'd2);

    // stall with a pending branch at pc=5
    repeat (2) fetch_one(1'b0, '0);
    wait_valid();
    check("pc_is_5", {32'h0, pc}, 64'd5);
    snap_instr = instruction; snap_pc = pc; snap_pc1 = pc_plus1;
    stall = 1'b1; br_taken = 1'b1; br_target = 32'd40;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_instr", {32'h0, instruction}, {32'h0, snap_instr});
      check("stall_pc", {32'h0, pc}, {32'h0, snap_pc});
      check("stall_pc_plus1", {32'h0, pc_plus1}, {32'h0, snap_pc1});
      check("stall_valid", {63'h0, instr_valid}, 64'h1);
      check("stall_no_req", {63'h0, imem_req}, 64'h0);
    end
    // release: branch to 40, then slow memory with a stray rvalid in REQ
    mem_lat = 5; stray_en = 1'b1; wait_cycles = 0;
    stall = 1'b0;
    tick();
    br_taken = 1'b0;
    check("branch_req", {63'h0, imem_req}, 64'h1);
    check("branch_addr", {32'h0, imem_addr}, 64'd40);
    check("branch_retired", {32'h0, retired}, 64'd6);
    tick();
    stray_en = 1'b0;
    wait_valid();
    check("wait_cycles_5", wait_cycles, 64'd5);
    check("slow_pc", {32'h0, pc}, 64'd40);
    check("slow_instr", {32'h0, instruction}, {32'h0, mem_word(32'd40)});

    // randomized stalls, branches and memory latency
    rand_lat = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int ns;
      wait_valid();
      ns = int'($urandom_range(0, 2));
      for (int s = 0; s < ns; s++) begin
        stall = 1'b1;
        br_taken = 1'($urandom_range(0, 1));
        br_target = $urandom;
        tick();
      end
      fetch_one(($urandom_range(0, 3) == 0), $urandom);
    end
    rand_lat = 1'b0;

    // reset during WAIT; a response arriving afterwards must be dropped
    wait_valid();
    mem_lat = 8;
    fetch_one(1'b0, '0);
    tick();
    check("pre_reset_wait", {62'h0, state}, {62'h0, WAIT});
    reset = 1'b1; inj_en = 1'b1; inj_data = 32'hDEAD_BEEF;
    #1;
    check("async_state", {62'h0, state}, {62'h0, IDLE});
    check("async_pc", {32'h0, pc}, 64'h0);
    m_pc = '0; m_retired = '0; prev_valid = 1'b0;
    tick();
    inj_en = 1'b0; reset = 1'b0; mem_lat = 1;
    tick();
    check("post_reset_instr", {32'h0, instruction}, {32'h0, NOP_INSTR});
    check("post_reset_req", {63'h0, imem_req}, 64'h1);
    check("post_reset_addr", {32'h0, imem_addr}, 64'h0);
    wait_valid();
    check("post_reset_fetch", {32'h0, instruction}, {32'h0, mem_word(32'h0)});

    // PC wrap from RESET_PC = 32'hFFFF_FFFF
    @(negedge clk);
    check("wrap_rst_pc_plus1", {32'h0, pc_plus1_2}, 64'h0);
    reset2 = 1'b0;
    @(negedge clk);
    check("wrap_req", {63'h0, imem_req2}, 64'h1);
    check("wrap_req_addr", {32'h0, imem_addr2}, 64'hFFFF_FFFF);
    @(negedge clk);
    imem_rvalid2 = 1'b1; imem_rdata2 = 32'h0000_0093;
    @(negedge clk);
    imem_rvalid2 = 1'b0;
    check("wrap_valid", {63'h0, instr_valid2}, 64'h1);
    check("wrap_pc", {32'h0, pc2}, 64'hFFFF_FFFF);
    check("wrap_pc_plus1", {32'h0, pc_plus1_2}, 64'h0);
    @(negedge clk);
    check("wrap_next_req", {63'h0, imem_req2}, 64'h1);
    check("wrap_next_addr", {32'h0, imem_addr2}, 64'h0);
    check("wrap_retired", {32'h0, retired2}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
